// File: rtl/total_alu_md_if.sv
// Execute-stage bus for total_alu_md: operation select, operands, launch strobe
// and the combinational result plus HI/LO engine status.
interface total_alu_md_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output ctl, a, b, shamt, start,
        input  result, busy, done, hi, lo
    );

    modport slave (
        input  ctl, a, b, shamt, start,
        output result, busy, done, hi, lo
    );
endinterface

// File: rtl/total_alu_md.sv
// EX-stage unit: zero-latency ALU/shifter plus an iterative unsigned
// multiply/divide engine (one bit per cycle) feeding the HI/LO registers.
module total_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic           clk,
    input logic           rst,
    total_alu_md_if.slave bus
);
    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_SRL   = 4'b0011;
    localparam logic [3:0] CTL_SLL   = 4'b0100;
    localparam logic [3:0] CTL_SRA   = 4'b0101;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MULTU = 4'b1000;
    localparam logic [3:0] CTL_DIVU  = 4'b1001;
    localparam logic [3:0] CTL_MFHI  = 4'b1010;
    localparam logic [3:0] CTL_MFLO  = 4'b1011;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q;
    logic [SHW:0]     count_q;
    logic             isDiv_q;
    logic [WIDTH-1:0] accHi_q;
    logic [WIDTH-1:0] accLo_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic [WIDTH-1:0] accHi_d;
    logic [WIDTH-1:0] accLo_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic             divFits;

    always_comb begin
        result_d = '0;
        case (bus.ctl)
            CTL_AND:  result_d = bus.a & bus.b;
            CTL_OR:   result_d = bus.a | bus.b;
            CTL_ADD:  result_d = bus.a + bus.b;
            CTL_SUB:  result_d = bus.a - bus.b;
            CTL_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CTL_SRL:  result_d = bus.b >> bus.shamt;
            CTL_SLL:  result_d = bus.b << bus.shamt;
            CTL_SRA:  result_d = $signed(bus.b) >>> bus.shamt;
            CTL_MFHI: result_d = hi_q;
            CTL_MFLO: result_d = lo_q;
            default:  result_d = '0;
        endcase
    end

    // accHi/accLo is the double-width working register: partial product and
    // multiplier for MULTU, partial remainder and dividend/quotient for DIVU.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
        remShift = {accHi_q, accLo_q[WIDTH-1]};
        divFits  = remShift >= {1'b0, opB_q};
        if (isDiv_q) begin
            accHi_d = divFits ? (remShift[WIDTH-1:0] - opB_q) : remShift[WIDTH-1:0];
            accLo_d = {accLo_q[WIDTH-2:0], divFits};
        end else begin
            accHi_d = mulSum[WIDTH:1];
            accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end
    end

    // A zero divisor always "fits", so the quotient saturates to all ones and
    // the remainder ends up equal to the dividend without special casing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            isDiv_q <= 1'b0;
            accHi_q <= '0;
            accLo_q <= '0;
            opB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (bus.ctl == CTL_MULTU || bus.ctl == CTL_DIVU)) begin
                        state_q <= S_BUSY;
                        count_q <= CNT_INIT;
                        isDiv_q <= (bus.ctl == CTL_DIVU);
                        accHi_q <= '0;
                        accLo_q <= bus.a;
                        opB_q   <= bus.b;
                    end
                end
                S_BUSY: begin
                    accHi_q <= accHi_d;
                    accLo_q <= accLo_d;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_q <= S_IDLE;
                        hi_q    <= accHi_d;
                        lo_q    <= accLo_d;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.result = result_d;
    assign bus.busy   = (state_q == S_BUSY);
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: doc/total_alu_md.md
Name: total_alu_md

Overview:
Parametrised successor to the pipeline's combined ALU/shifter execute unit. The unit has two parts:
- Combinational path: logic, add/sub, set-less-than and full shift operations (SRL/SLL/SRA).
- Sequential path: an iterative unsigned multiply/divide engine with architectural HI/LO registers, read through MFHI/MFLO.
It sits in the EX stage. The hazard unit stalls the pipeline while busy=1.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >=8)
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
ctl  in  4  operation select
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm); shift source
shamt  in  SHW  shift amount
start  in  1  launch MULTU/DIVU when ctl selects one
result  out  WIDTH  combinational result
busy  out  1  mul/div engine running
done  out  1  one-cycle pulse when HI/LO updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- ctl encoding and result (combinational, zero latency):
  - 0000 AND; 0001 OR.
  - 0010 ADD, mod 2^WIDTH, no overflow trap.
  - 0110 SUB, a-b mod 2^WIDTH.
  - 0111 SLT: signed compare, result = {0..,1} if a<b else 0.
  - 0011 SRL: b>>shamt, zero fill.
  - 0100 SLL: b<<shamt.
  - 0101 SRA: b>>>shamt, sign fill.
  - 1000 MULTU, 1001 DIVU: result=0.
  - 1010 MFHI: result=hi; 1011 MFLO: result=lo.
  - All other codes: result=0.
- Reset (rst=1 at a clk edge):
  - hi=0, lo=0, busy=0, done=0, internal counter=0.
  - Any in-flight operation is aborted with no HI/LO write.
  - rst has priority over start.
- Launch:
  - Condition: at a clk edge, start=1, ctl in {1000,1001} and busy=0.
  - The edge latches a, b and the operation, loads count=WIDTH and sets busy<=1.
  - start with any other ctl is ignored.
  - start while busy=1 is ignored; latched operands are unaffected.
- Iteration: each edge with busy=1 performs one step and decrements count.
  - MULTU: shift-add, 2*WIDTH-bit product.
  - DIVU: restoring division, 1 quotient bit per step.
- Completion: the edge performing the final step (count 1->0):
  - writes hi/lo, busy<=0, done<=1;
  - done deasserts on the next edge.
- Latency: with start sampled at edge E0, busy is high for exactly WIDTH cycles (edges E1..EWIDTH). hi/lo update and done=1 occur after edge EWIDTH.
- Relaunch: a new start may be accepted on the same edge at which done deasserts, i.e. the first edge with busy=0.
- Results:
  - MULTU: {hi,lo} = a*b, unsigned.
  - DIVU: lo = a/b, hi = a%b, unsigned.
  - Divide by zero: lo = all ones, hi = a. No trap.
- HI/LO visibility: hi/lo hold their previous values throughout busy. MFHI/MFLO during busy return the old values; the stall is the hazard unit's job.
- The combinational path stays fully functional while busy=1.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001 -> result=0x00000000. SUB 3-5 -> 0xFFFFFFFE. SLT a=0xFFFFFFFF, b=1 -> 1.
- SRA b=0x80000000, shamt=4 -> 0xF8000000. SRL same -> 0x08000000. SLL b=1, shamt=31 -> 0x80000000.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0:
  - busy=1 for 32 cycles;
  - after E32: hi=0xFFFFFFFE, lo=0x00000001, done=1 for exactly one cycle;
  - MFLO during busy returns old lo.
- DIVU 100/7 -> lo=14, hi=2. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Ignored starts:
  - start with MULTU 2*3 at E5 of a running DIVU -> ignored, DIVU result unchanged;
  - start with ctl=ADD -> busy stays 0.
- Reset mid-op: rst=1 at E10 of a MULTU -> busy=0, done=0, hi=lo=0 on the next cycle, no later done pulse. After reset, MFHI -> 0.
